// File: rtl/ce_tick_pkg.sv
// Shared types and constants for the CE tick generator and its button debouncers.
package ce_tick_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2
   } state_t;

   localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/ce_tick_gen_if.sv
// Control/status bundle between the board-side controls and the CE tick generator.
interface ce_tick_gen_if #(
   parameter int DIV_W = 32
);

   logic             LOCKED;
   logic             BTN_RUN;
   logic             BTN_STEP;
   logic [DIV_W-1:0] DIV;
   logic             CE;
   logic             RUNNING;

   modport master (
      output LOCKED, BTN_RUN, BTN_STEP, DIV,
      input  CE, RUNNING
   );

   modport slave (
      input  LOCKED, BTN_RUN, BTN_STEP, DIV,
      output CE, RUNNING
   );

endinterface

// File: rtl/btn_debounce.sv
// Synchronizes a raw button, debounces it, and emits a one-cycle pulse on each
// debounced rising edge.
module btn_debounce
   import ce_tick_pkg::*;
#(
   parameter int DB_CYCLES = 16
) (
   input  logic CLK,
   input  logic R_N,
   input  logic BTN,
   output logic LEVEL,
   output logic PRESS
);

   localparam int CNT_W = $clog2(DB_CYCLES + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt;
   logic                   level_q;
   logic                   level_d;
   logic                   synced;

   assign synced = sync_q[SYNC_STAGES-1];

   // The level only flips once the synced input has disagreed for DB_CYCLES edges in a row.
   always_ff @(posedge CLK or negedge R_N) begin
      if (!R_N) begin
         sync_q  <= '0;
         cnt     <= '0;
         level_q <= 1'b0;
         level_d <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], BTN};
         level_d <= level_q;
         if (synced == level_q) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
            cnt     <= '0;
            level_q <= ~level_q;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign LEVEL = level_q;
   assign PRESS = level_q & ~level_d;

endmodule

// File: rtl/ce_tick_gen.sv
// Run/step control FSM and prescaler that produce the counter's count-enable pulse.
module ce_tick_gen
   import ce_tick_pkg::*;
#(
   parameter int DIV_W     = 32,
   parameter int DB_CYCLES = 16
) (
   input  logic          CLK,
   input  logic          R_N,
   ce_tick_gen_if.slave  bus
);

   state_t           state;
   logic [DIV_W-1:0] prescaler;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_eff;
   logic             ce_q;
   logic             running_q;
   logic             run_press;
   logic             step_press;
   logic             wrap;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_run_db (
      .CLK   (CLK),
      .R_N   (R_N),
      .BTN   (bus.BTN_RUN),
      .LEVEL (),
      .PRESS (run_press)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
      .CLK   (CLK),
      .R_N   (R_N),
      .BTN   (bus.BTN_STEP),
      .LEVEL (),
      .PRESS (step_press)
   );

   assign div_eff = (bus.DIV == '0) ? DIV_W'(1) : bus.DIV;
   assign wrap    = (prescaler == (div_q - DIV_W'(1)));

   // Loss of lock overrides everything; a RUN press beats a STEP press and any pending wrap.
   always_ff @(posedge CLK or negedge R_N) begin
      if (!R_N) begin
         state     <= IDLE;
         prescaler <= '0;
         div_q     <= DIV_W'(1);
         ce_q      <= 1'b0;
         running_q <= 1'b0;
      end else if (!bus.LOCKED) begin
         state     <= IDLE;
         prescaler <= '0;
         ce_q      <= 1'b0;
         running_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ce_q <= 1'b0;
               if (run_press) begin
                  state     <= RUN;
                  running_q <= 1'b1;
                  prescaler <= '0;
                  div_q     <= div_eff;
               end else if (step_press) begin
                  state <= STEP;
                  ce_q  <= 1'b1;
               end
            end
            RUN: begin
               if (run_press) begin
                  state     <= IDLE;
                  running_q <= 1'b0;
                  prescaler <= '0;
                  ce_q      <= 1'b0;
               end else if (wrap) begin
                  prescaler <= '0;
                  div_q     <= div_eff;
                  ce_q      <= 1'b1;
               end else begin
                  prescaler <= prescaler + DIV_W'(1);
                  ce_q      <= 1'b0;
               end
            end
            STEP: begin
               state <= IDLE;
               ce_q  <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               ce_q      <= 1'b0;
               running_q <= 1'b0;
               prescaler <= '0;
            end
         endcase
      end
   end

   assign bus.CE      = ce_q;
   assign bus.RUNNING = running_q;

endmodule

// File: tb/tb_ce_tick_gen.sv
// Directed bench for ce_tick_gen with DB_CYCLES=4: a held button takes effect on the 7th edge.
module tb_ce_tick_gen;

   logic CLK;
   logic R_N;
   int   checks;
   int   errors;

   ce_tick_gen_if #(.DIV_W(32)) bus ();

   ce_tick_gen #(.DIV_W(32), .DB_CYCLES(4)) dut (
      .CLK (CLK),
      .R_N (R_N),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic applyStimulus(input logic run, input logic step);
      bus.BTN_RUN  = run;
      bus.BTN_STEP = step;
   endtask

   task automatic checkOutput(input string tag, input logic ceExp, input logic runExp);
      checks++;
      assert (bus.CE === ceExp)
      else begin
         errors++;
         $error("[TB] FAIL %s CE observed %b expected %b at %0t", tag, bus.CE, ceExp, $time);
      end
      checks++;
      assert (bus.RUNNING === runExp)
      else begin
         errors++;
         $error("[TB] FAIL %s RUNNING observed %b expected %b at %0t", tag, bus.RUNNING, runExp, $time);
      end
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      R_N          = 1'b0;
      bus.LOCKED   = 1'b1;
      bus.DIV      = 32'd5;
      applyStimulus(1'b0, 1'b0);

      cycle();
      cycle();
      checkOutput("reset", 1'b0, 1'b0);
      R_N = 1'b1;
      for (int i = 1; i <= 50; i++) begin
         cycle();
         checkOutput("idle", 1'b0, 1'b0);
      end

      // RUN with DIV=5: entry on edge 7, CE every 5th edge after that
      applyStimulus(1'b1, 1'b0);
      for (int i = 1; i <= 22; i++) begin
         cycle();
         checkOutput("run_div5", (i > 7) && ((i - 7) % 5 == 0), i >= 7);
         if (i == 10) applyStimulus(1'b0, 1'b0);
      end
      applyStimulus(1'b1, 1'b0);
      for (int m = 1; m <= 7; m++) begin
         cycle();
         checkOutput("stop_div5", (m < 7) && ((15 + m) % 5 == 0), m < 7);
      end
      for (int i = 8; i <= 30; i++) begin
         cycle();
         checkOutput("stopped", 1'b0, 1'b0);
         if (i == 10) applyStimulus(1'b0, 1'b0);
      end

      // Single step: one CE pulse on edge 7
      applyStimulus(1'b0, 1'b1);
      for (int i = 1; i <= 20; i++) begin
         cycle();
         checkOutput("step", i == 7, 1'b0);
         if (i == 6) applyStimulus(1'b0, 1'b0);
      end

      // 3-cycle glitch is shorter than the debounce window
      applyStimulus(1'b0, 1'b1);
      for (int i = 1; i <= 20; i++) begin
         cycle();
         checkOutput("glitch", 1'b0, 1'b0);
         if (i == 3) applyStimulus(1'b0, 1'b0);
      end

      // DIV=0 and DIV=1 keep CE high; then 8 -> 3 mid-period
      bus.DIV = 32'd0;
      applyStimulus(1'b1, 1'b0);
      for (int i = 1; i <= 30; i++) begin
         cycle();
         checkOutput("div_0_1", i >= 8, i >= 7);
         if (i == 10) applyStimulus(1'b0, 1'b0);
         if (i == 20) bus.DIV = 32'd1;
      end
      bus.DIV = 32'd8;
      for (int i = 1; i <= 18; i++) begin
         cycle();
         checkOutput("div_8_3", (i == 1) || (i == 9) || (i == 12) || (i == 15) || (i == 18), 1'b1);
         if (i == 4) bus.DIV = 32'd3;
      end
      applyStimulus(1'b1, 1'b0);
      for (int m = 1; m <= 7; m++) begin
         cycle();
         checkOutput("stop_div3", (m == 3) || (m == 6), m < 7);
      end
      for (int i = 8; i <= 30; i++) begin
         cycle();
         checkOutput("stopped3", 1'b0, 1'b0);
         if (i == 10) applyStimulus(1'b0, 1'b0);
      end

      // Simultaneous RUN+STEP: RUN wins; later STEP in RUN leaves cadence alone
      bus.DIV = 32'd4;
      applyStimulus(1'b1, 1'b1);
      for (int i = 1; i <= 40; i++) begin
         cycle();
         checkOutput("simul", (i > 7) && ((i - 7) % 4 == 0), i >= 7);
         if (i == 10) applyStimulus(1'b0, 1'b0);
         if (i == 16) applyStimulus(1'b0, 1'b1);
         if (i == 26) applyStimulus(1'b0, 1'b0);
      end
      applyStimulus(1'b1, 1'b0);
      for (int m = 1; m <= 7; m++) begin
         cycle();
         checkOutput("stop_wins", (m < 7) && ((33 + m) % 4 == 0), m < 7);
      end
      for (int i = 8; i <= 30; i++) begin
         cycle();
         checkOutput("stopped4", 1'b0, 1'b0);
         if (i == 10) applyStimulus(1'b0, 1'b0);
      end

      // Lock loss mid-run, then a press while unlocked is discarded
      bus.DIV = 32'd2;
      applyStimulus(1'b1, 1'b0);
      for (int i = 1; i <= 12; i++) begin
         cycle();
         checkOutput("run_div2", (i > 7) && ((i - 7) % 2 == 0), i >= 7);
         if (i == 10) applyStimulus(1'b0, 1'b0);
      end
      bus.LOCKED = 1'b0;
      cycle();
      checkOutput("lock_loss", 1'b0, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         cycle();
         checkOutput("unlocked", 1'b0, 1'b0);
      end
      applyStimulus(1'b1, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         cycle();
         checkOutput("unlocked_press", 1'b0, 1'b0);
         if (i == 10) applyStimulus(1'b0, 1'b0);
      end
      bus.LOCKED = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         cycle();
         checkOutput("relocked", 1'b0, 1'b0);
      end

      // Asynchronous reset mid-run clears outputs without waiting for an edge
      bus.DIV = 32'd1;
      applyStimulus(1'b1, 1'b0);
      for (int i = 1; i <= 12; i++) begin
         cycle();
         checkOutput("run_div1", i >= 8, i >= 7);
      end
      #2;
      R_N = 1'b0;
      #1;
      checkOutput("async_reset", 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      cycle();
      cycle();
      checkOutput("in_reset", 1'b0, 1'b0);
      R_N = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         cycle();
         checkOutput("post_reset", 1'b0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ce_tick_gen.md
Name: ce_tick_gen

Overview:
- Upstream control stage for the 32-bit binary counter; drives that counter's CE input from the divided clock domain.
- Turns two raw board buttons (RUN toggle, single STEP) into clean one-cycle CE pulses at a programmable rate.
- Gated by the clock wizard's LOCKED so the counter never advances on an unstable clock.

Parameters:
- DIV_W, 32, width of the divisor input and the prescaler.
- DB_CYCLES, 16, number of consecutive stable synchronized samples required before a debounced button level changes (≥2).

Ports:
- CLK  in  1  divided clock (clk_out1 of clock wizard).
- R_N  in  1  asynchronous active-low reset.
- LOCKED  in  1  clock wizard lock; 0 forces stop.
- BTN_RUN  in  1  raw asynchronous run/stop toggle button.
- BTN_STEP  in  1  raw asynchronous single-step button.
- DIV  in  DIV_W  CE period in CLK cycles; 0 is treated as 1.
- CE  out  1  registered one-cycle count-enable pulse to the counter.
- RUNNING  out  1  registered; 1 while in RUN.

Behaviour:
- Reset (R_N=0, async): CE=0, RUNNING=0, state IDLE, prescaler=0, sync flops=0, debounced levels=0, debounce counters=0, div_q=1.
- Input path per button: 2-FF synchronizer; debounce counter increments each cycle sync≠level and clears when sync==level. The level flips on the edge where the counter would reach DB_CYCLES. Press = debounced level rising (level & ~level_d), one-cycle pulse. Release generates no event.
- Latency: BTN_RUN high and stable before edge 1 gives RUNNING=1 after edge DB_CYCLES+3. Pulses shorter than DB_CYCLES cycles produce no event.
- FSM states:
  - IDLE: CE=0. RUN press and LOCKED=1 -> RUN; prescaler:=0; div_q:=max(DIV,1). STEP press and LOCKED=1 -> STEP.
  - RUN: prescaler counts 0..div_q-1. When prescaler==div_q-1, CE=1 for the next cycle, prescaler:=0, and div_q reloads from DIV. First CE is high div_q cycles after entering RUN. RUN press -> IDLE with prescaler cleared. STEP press is ignored.
  - STEP: lasts exactly one cycle, during which CE=1, then returns to IDLE. Presses during STEP are ignored.
- CE and RUNNING are registered outputs with no combinational path from any input.
- DIV=0 or DIV=1: CE stays high continuously in RUN.
- DIV changes mid-run take effect only at the next wrap. The current period always completes with the old value.
- Simultaneous RUN and STEP presses in IDLE: RUN wins and STEP is dropped.
- LOCKED=0 in any state: next edge goes to IDLE, CE=0, RUNNING=0, prescaler=0. Presses while LOCKED=0 are discarded, not queued.
- Prescaler arithmetic is unsigned DIV_W bits. Comparison uses div_q-1 with div_q≥1, so there is no underflow.

Decomposition:
- Shared package ce_tick_pkg holds the state enum (IDLE, RUN, STEP) and the synchronizer depth constant (2).
- One sub-module, btn_debounce (parameter DB_CYCLES; ports CLK, R_N, BTN, LEVEL, PRESS), is instantiated twice.
- The FSM and prescaler stay in ce_tick_gen.

Test Plan:
- Reset/idle: DB_CYCLES=4, LOCKED=1, R_N low then high, no buttons for 50 cycles -> CE=0 and RUNNING=0 throughout.
- Run/stop timing: DIV=5, BTN_RUN high for 10 cycles -> RUNNING=1 after edge 7. CE pulses at cycles 5, 10, 15… after entry, each 1 cycle wide. Second press -> RUNNING=0, no further CE.
- Step and glitch: in IDLE, BTN_STEP high for 6 cycles -> exactly one CE pulse. A 3-cycle BTN_STEP glitch -> no CE.
- DIV edges: DIV=0 then DIV=1 in RUN -> CE continuously high. Change DIV from 8 to 3 mid-period -> current gap stays 8, subsequent gaps are 3.
- Simultaneous and ignored presses: RUN and STEP pressed together in IDLE -> RUN only, no extra CE. STEP pressed during RUN -> CE cadence unchanged.
- Lock loss and reset mid-run: LOCKED falls in RUN -> RUNNING=0 and CE=0 on the next edge. A RUN press while unlocked is ignored after LOCKED returns. R_N pulsed mid-run -> all outputs 0 immediately (async).
